// File: rtl/risc_pkg.sv
// Shared memory-size encoding plus LSU state type and size helper.
// Used by lsu_dmem_master; optional split support is LSU_MISALIGN_SPLIT_EN.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10,
        RESP   = 2'b11
    } lsu_state_t;

    // Zero marks an illegal size encoding.
    function automatic logic [2:0] size_bytes(input mem_size_t size);
        case (size)
            BYTE:      size_bytes = 3'd1;
            HALF_WORD: size_bytes = 3'd2;
            WORD:      size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled little-endian load value by access size.
module lsu_load_extend
    import risc_pkg::*;
(
    input  logic [31:0] data,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (size)
            BYTE:      result = is_unsigned ? {24'b0, data[7:0]}  : {{24{data[7]}}, data[7:0]};
            HALF_WORD: result = is_unsigned ? {16'b0, data[15:0]} : {{16{data[15]}}, data[15:0]};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving the byte-wide data memory request bus.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into byte beats.
module lsu_dmem_master
    import risc_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_wr_en,
    input  mem_size_t   lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wr_data,
    output logic        lsu_done,
    output logic [31:0] lsu_rd_data,
    output logic        lsu_err,
    output logic        dmem_req,
    output logic        dmem_wr_en,
    output mem_size_t   dmem_data_size,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wr_data,
    output logic        dmem_zero_extend,
    input  logic [31:0] dmem_rd_data
);

    lsu_state_t  state;
    logic        req_wr_en;
    logic [2:0]  in_bytes;
    logic [32:0] end_addr;
    logic        out_of_range;
    logic        misaligned;
    logic        illegal_size;
    logic        reject;

    assign in_bytes     = size_bytes(lsu_size);
    // 33-bit end address so a wrap past 2^32 reads as out of range.
    assign end_addr     = {1'b0, lsu_addr} + {30'b0, in_bytes} - 33'd1;
    assign out_of_range = |end_addr[32:DMEM_ADDR_WIDTH];
    assign illegal_size = (in_bytes == 3'd0);
    assign misaligned   = ((lsu_size == HALF_WORD) && lsu_addr[0]) ||
                          ((lsu_size == WORD) && (lsu_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic [1:0]  beat;
    logic [31:0] assembly;
    logic [31:0] assembled;
    logic [31:0] split_result;
    logic [2:0]  req_bytes;
    logic        last_beat;

    assign reject    = illegal_size || out_of_range;
    assign req_bytes = size_bytes(req_size);
    assign last_beat = ({1'b0, beat} == (req_bytes - 3'd1));

    always_comb begin
        assembled = assembly;
        assembled[{beat, 3'b000} +: 8] = dmem_rd_data[7:0];
    end

    lsu_load_extend u_load_extend (
        .data        (assembled),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .result      (split_result)
    );
`else
    assign reject = illegal_size || out_of_range || misaligned;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lsu_ready        <= 1'b1;
            lsu_done         <= 1'b0;
            lsu_err          <= 1'b0;
            lsu_rd_data      <= 32'b0;
            dmem_req         <= 1'b0;
            dmem_wr_en       <= 1'b0;
            dmem_data_size   <= BYTE;
            dmem_addr        <= 32'b0;
            dmem_wr_data     <= 32'b0;
            dmem_zero_extend <= 1'b0;
            req_wr_en        <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            req_size         <= BYTE;
            req_unsigned     <= 1'b0;
            req_addr         <= 32'b0;
            req_wr_data      <= 32'b0;
            beat             <= 2'b0;
            assembly         <= 32'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        req_wr_en <= lsu_wr_en;
                        lsu_ready <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        req_size     <= lsu_size;
                        req_unsigned <= lsu_unsigned;
                        req_addr     <= lsu_addr;
                        req_wr_data  <= lsu_wr_data;
                        beat         <= 2'b0;
                        assembly     <= 32'b0;
`endif
                        if (reject) begin
                            state    <= RESP;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                            if (!lsu_wr_en) lsu_rd_data <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        end else if (misaligned) begin
                            state            <= SPLIT;
                            dmem_req         <= 1'b1;
                            dmem_wr_en       <= lsu_wr_en;
                            dmem_data_size   <= BYTE;
                            dmem_addr        <= lsu_addr;
                            dmem_wr_data     <= {24'b0, lsu_wr_data[7:0]};
                            dmem_zero_extend <= 1'b1;
`endif
                        end else begin
                            state            <= ACCESS;
                            dmem_req         <= 1'b1;
                            dmem_wr_en       <= lsu_wr_en;
                            dmem_data_size   <= lsu_size;
                            dmem_addr        <= lsu_addr;
                            dmem_wr_data     <= lsu_wr_data;
                            dmem_zero_extend <= lsu_unsigned;
                        end
                    end
                end
                ACCESS: begin
                    dmem_req         <= 1'b0;
                    dmem_wr_en       <= 1'b0;
                    dmem_data_size   <= BYTE;
                    dmem_addr        <= 32'b0;
                    dmem_wr_data     <= 32'b0;
                    dmem_zero_extend <= 1'b0;
                    if (!req_wr_en) lsu_rd_data <= dmem_rd_data;
                    state    <= RESP;
                    lsu_done <= 1'b1;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                SPLIT: begin
                    if (!req_wr_en) assembly <= assembled;
                    if (last_beat) begin
                        dmem_req         <= 1'b0;
                        dmem_wr_en       <= 1'b0;
                        dmem_data_size   <= BYTE;
                        dmem_addr        <= 32'b0;
                        dmem_wr_data     <= 32'b0;
                        dmem_zero_extend <= 1'b0;
                        if (!req_wr_en) lsu_rd_data <= split_result;
                        state    <= RESP;
                        lsu_done <= 1'b1;
                    end else begin
                        beat         <= beat + 2'd1;
                        dmem_addr    <= req_addr + 32'(beat) + 32'd1;
                        dmem_wr_data <= {24'b0, req_wr_data[{beat + 2'd1, 3'b000} +: 8]};
                    end
                end
`endif
                RESP: begin
                    lsu_done  <= 1'b0;
                    lsu_err   <= 1'b0;
                    lsu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed table-driven bench for lsu_dmem_master with a byte-wide memory model.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined.
module tb_lsu_dmem_master;
    import risc_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_wr_en;
    mem_size_t   lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wr_data;
    logic        lsu_done;
    logic [31:0] lsu_rd_data;
    logic        lsu_err;
    logic        dmem_req;
    logic        dmem_wr_en;
    mem_size_t   dmem_data_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_zero_extend;
    logic [31:0] dmem_rd_data;

    lsu_dmem_master #(.DMEM_ADDR_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .lsu_valid        (lsu_valid),
        .lsu_ready        (lsu_ready),
        .lsu_wr_en        (lsu_wr_en),
        .lsu_size         (lsu_size),
        .lsu_unsigned     (lsu_unsigned),
        .lsu_addr         (lsu_addr),
        .lsu_wr_data      (lsu_wr_data),
        .lsu_done         (lsu_done),
        .lsu_rd_data      (lsu_rd_data),
        .lsu_err          (lsu_err),
        .dmem_req         (dmem_req),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_data_size   (dmem_data_size),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_rd_data     (dmem_rd_data)
    );

    always #5 clk = ~clk;

    // Byte-wide memory: combinational reads with extension, writes on the clock edge.
    logic [7:0] mem [0:65535];

    function automatic logic [31:0] memRead(input logic en, input logic [31:0] a,
                                            input mem_size_t s, input logic z);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a[15:0]];
        b1 = mem[a[15:0] + 16'd1];
        b2 = mem[a[15:0] + 16'd2];
        b3 = mem[a[15:0] + 16'd3];
        if (!en)              memRead = 32'b0;
        else if (s == BYTE)   memRead = z ? {24'b0, b0} : {{24{b0[7]}}, b0};
        else if (s == HALF_WORD) memRead = z ? {16'b0, b1, b0} : {{16{b1[7]}}, b1, b0};
        else                  memRead = {b3, b2, b1, b0};
    endfunction

    assign dmem_rd_data = memRead(dmem_req && !dmem_wr_en, dmem_addr, dmem_data_size, dmem_zero_extend);

    always @(posedge clk) begin
        if (dmem_req && dmem_wr_en) begin
            mem[dmem_addr[15:0]] <= dmem_wr_data[7:0];
            if (dmem_data_size != BYTE) mem[dmem_addr[15:0] + 16'd1] <= dmem_wr_data[15:8];
            if (dmem_data_size == WORD) begin
                mem[dmem_addr[15:0] + 16'd2] <= dmem_wr_data[23:16];
                mem[dmem_addr[15:0] + 16'd3] <= dmem_wr_data[31:24];
            end
        end
    end

    int done_count = 0;
    always @(posedge clk) if (lsu_done) done_count <= done_count + 1;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    typedef struct {
        logic        wr_en;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_reqs;
    } vec_t;

    function automatic vec_t mk(input logic wr_en, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic chk_rd, input logic [31:0] exp_rd,
                                input logic exp_err, input int exp_lat, input int exp_reqs);
        mk.wr_en = wr_en;   mk.size = size;       mk.uns = uns;
        mk.addr = addr;     mk.wdata = wdata;     mk.chk_rd = chk_rd;
        mk.exp_rd = exp_rd; mk.exp_err = exp_err; mk.exp_lat = exp_lat;
        mk.exp_reqs = exp_reqs;
    endfunction

    logic [31:0] beat_addr [0:7];
    logic        beat_zext [0:7];
    mem_size_t   beat_size [0:7];

    // Issue one request and follow it to its done pulse, recording memory beats.
    task automatic applyStimulus(input vec_t v, output int lat, output int reqs,
                                 output logic err, output logic [31:0] rd);
        lat = -1; reqs = 0; err = 1'b0; rd = 32'b0;
        @(negedge clk);
        checkOutput("ready_at_accept", {31'b0, lsu_ready}, 32'd1);
        lsu_valid    = 1'b1;
        lsu_wr_en    = v.wr_en;
        lsu_size     = mem_size_t'(v.size);
        lsu_unsigned = v.uns;
        lsu_addr     = v.addr;
        lsu_wr_data  = v.wdata;
        @(negedge clk);
        lsu_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (dmem_req) begin
                if (reqs < 8) begin
                    beat_addr[reqs] = dmem_addr;
                    beat_zext[reqs] = dmem_zero_extend;
                    beat_size[reqs] = dmem_data_size;
                end
                reqs++;
            end
            if (lsu_done) begin
                lat = k;
                err = lsu_err;
                rd  = lsu_rd_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs [0:21];

    initial begin
        int lat, reqs, dc0, acc;
        logic err;
        logic [31:0] rd;
        logic [8:0] ready_pat;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // idx: wr uns size addr wdata chk_rd exp_rd err lat reqs
        vecs[0]  = mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0, 2, 1);
        vecs[1]  = mk(0, 2'b10, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 2, 1);
        vecs[2]  = mk(0, 2'b00, 0, 32'h103, 32'h0, 1, 32'hFFFFFFDE, 0, 2, 1);
        vecs[3]  = mk(0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h000000DE, 0, 2, 1);
        vecs[4]  = mk(0, 2'b01, 0, 32'h102, 32'h0, 1, 32'hFFFFDEAD, 0, 2, 1);
        vecs[5]  = mk(0, 2'b01, 1, 32'h100, 32'h0, 1, 32'h0000BEEF, 0, 2, 1);
        vecs[6]  = mk(1, 2'b10, 0, 32'h104, 32'h11223344, 1, 32'h0000BEEF, 0, 2, 1);
        vecs[7]  = mk(0, 2'b10, 0, 32'h101, 32'h0, 1, SPLIT_ON ? 32'h44DEADBE : 32'h0,
                      !SPLIT_ON, SPLIT_ON ? 5 : 1, SPLIT_ON ? 4 : 0);
        vecs[8]  = mk(0, 2'b01, 0, 32'h101, 32'h0, 1, SPLIT_ON ? 32'hFFFFADBE : 32'h0,
                      !SPLIT_ON, SPLIT_ON ? 3 : 1, SPLIT_ON ? 2 : 0);
        vecs[9]  = mk(0, 2'b01, 1, 32'h101, 32'h0, 1, SPLIT_ON ? 32'h0000ADBE : 32'h0,
                      !SPLIT_ON, SPLIT_ON ? 3 : 1, SPLIT_ON ? 2 : 0);
        vecs[10] = mk(1, 2'b10, 0, 32'hFFFC, 32'hCAFEF00D, 0, 32'h0, 0, 2, 1);
        vecs[11] = mk(0, 2'b10, 0, 32'hFFFC, 32'h0, 1, 32'hCAFEF00D, 0, 2, 1);
        vecs[12] = mk(0, 2'b10, 0, 32'hFFFE, 32'h0, 1, 32'h0, 1, 1, 0);
        vecs[13] = mk(0, 2'b00, 0, 32'h10000, 32'h0, 1, 32'h0, 1, 1, 0);
        vecs[14] = mk(0, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1, 1, 0);
        vecs[15] = mk(0, 2'b11, 0, 32'h200, 32'h0, 1, 32'h0, 1, 1, 0);
        vecs[16] = mk(1, 2'b01, 0, 32'h240, 32'hABCD1234, 0, 32'h0, 0, 2, 1);
        vecs[17] = mk(0, 2'b01, 1, 32'h240, 32'h0, 1, 32'h00001234, 0, 2, 1);
        vecs[18] = mk(0, 2'b00, 0, 32'h241, 32'h0, 1, 32'h00000012, 0, 2, 1);
        vecs[19] = mk(1, 2'b01, 0, 32'h2F1, 32'h00005566, 0, 32'h0,
                      !SPLIT_ON, SPLIT_ON ? 3 : 1, SPLIT_ON ? 2 : 0);
        vecs[20] = mk(0, 2'b01, 1, 32'h2F1, 32'h0, 1, SPLIT_ON ? 32'h00005566 : 32'h0,
                      !SPLIT_ON, SPLIT_ON ? 3 : 1, SPLIT_ON ? 2 : 0);
        vecs[21] = mk(0, 2'b00, 1, 32'h2F2, 32'h0, 1, SPLIT_ON ? 32'h00000055 : 32'h0, 0, 2, 1);

        rst = 1'b1; lsu_valid = 1'b0; lsu_wr_en = 1'b0; lsu_size = BYTE;
        lsu_unsigned = 1'b0; lsu_addr = 32'b0; lsu_wr_data = 32'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", {31'b0, lsu_ready}, 32'd1);
        checkOutput("reset_done", {31'b0, lsu_done}, 32'd0);
        checkOutput("reset_err", {31'b0, lsu_err}, 32'd0);
        checkOutput("reset_rd_data", lsu_rd_data, 32'd0);
        checkOutput("reset_dmem_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("reset_dmem_addr", dmem_addr, 32'd0);
        checkOutput("reset_dmem_wr_data", dmem_wr_data, 32'd0);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i], lat, reqs, err, rd);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_req_cycles", i), 32'(reqs), 32'(vecs[i].exp_reqs));
            checkOutput($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            if (vecs[i].chk_rd) checkOutput($sformatf("v%0d_rd_data", i), rd, vecs[i].exp_rd);
            if (vecs[i].exp_reqs > 0) checkOutput($sformatf("v%0d_first_addr", i), beat_addr[0], vecs[i].addr);
        end

        // Misaligned LW 0x101: byte beats walk the address with zero_extend set.
        applyStimulus(vecs[7], lat, reqs, err, rd);
        checkOutput("split_beat_count", 32'(reqs), SPLIT_ON ? 32'd4 : 32'd0);
        for (int i = 0; i < reqs && i < 8; i++) begin
            checkOutput($sformatf("split_beat%0d_addr", i), beat_addr[i], 32'h101 + 32'(i));
            checkOutput($sformatf("split_beat%0d_zext", i), {31'b0, beat_zext[i]}, 32'd1);
            checkOutput($sformatf("split_beat%0d_size", i), {30'b0, beat_size[i]}, {30'b0, BYTE});
        end

        // Reset during the second beat of SW 0x201.
        @(negedge clk);
        dc0 = done_count;
        lsu_valid = 1'b1; lsu_wr_en = 1'b1; lsu_size = WORD; lsu_unsigned = 1'b0;
        lsu_addr = 32'h201; lsu_wr_data = 32'hA1B2C3D4;
        @(negedge clk);
        lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_dmem_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("midreset_ready", {31'b0, lsu_ready}, 32'd1);
        checkOutput("midreset_done", {31'b0, lsu_done}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("midreset_done_pulses", 32'(done_count - dc0), SPLIT_ON ? 32'd0 : 32'd1);
        checkOutput("midreset_mem201", {24'b0, mem[16'h201]}, SPLIT_ON ? 32'hD4 : 32'h00);
        checkOutput("midreset_mem202", {24'b0, mem[16'h202]}, SPLIT_ON ? 32'hC3 : 32'h00);
        checkOutput("midreset_mem203", {24'b0, mem[16'h203]}, 32'h00);

        // Back-to-back aligned loads with lsu_valid held high.
        lsu_valid = 1'b1; lsu_wr_en = 1'b0; lsu_size = WORD; lsu_unsigned = 1'b0;
        lsu_addr = 32'h100; lsu_wr_data = 32'h0;
        dc0 = done_count;
        acc = 0;
        ready_pat = 9'b0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            ready_pat[c] = lsu_ready;
            if (lsu_ready) acc++;
        end
        checkOutput("b2b_last_rd_data", lsu_rd_data, 32'hDEADBEEF);
        lsu_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("b2b_ready_pattern", {23'b0, ready_pat}, {23'b0, 9'b001001001});
        checkOutput("b2b_accepts", 32'(acc), 32'd3);
        checkOutput("b2b_done_pulses", 32'(done_count - dc0), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit that initiates data-memory transactions. It drives the dmem_* request bus of the byte-wide data memory: req, wr_en, size, addr, wr_data, zero_extend, with combinational rd_data returned.
- Sits between the execute stage and data memory. Accepts one load/store at a time from the pipeline over a valid/ready handshake and returns a one-cycle done pulse with the result.
- Performs range checking and, when the optional feature is built in, splits misaligned accesses into byte beats.

Parameters:
- DMEM_ADDR_WIDTH, 16, byte-address width of the data memory. Any byte touched at or above 2**DMEM_ADDR_WIDTH is out of range.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lsu_valid  in  1  pipeline request valid.
- lsu_ready  out  1  LSU can accept; high only in IDLE.
- lsu_wr_en  in  1  1 = store, 0 = load.
- lsu_size  in  mem_size_t  BYTE / HALF_WORD / WORD.
- lsu_unsigned  in  1  load zero-extends (LBU/LHU).
- lsu_addr  in  32  byte address.
- lsu_wr_data  in  32  store data, right-aligned.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rd_data  out  32  load result, registered.
- lsu_err  out  1  pulses with lsu_done: misaligned (feature off), out of range, or illegal size.
- dmem_req  out  1  memory request.
- dmem_wr_en  out  1  memory write enable.
- dmem_data_size  out  mem_size_t  access size.
- dmem_addr  out  32  memory byte address.
- dmem_wr_data  out  32  memory write data.
- dmem_zero_extend  out  1  memory load extension select.
- dmem_rd_data  in  32  combinational read data from memory.

Behaviour:
- Reset: state = IDLE. All outputs 0 except lsu_ready = 1. Internal request, assembly and beat registers cleared.
- Reset mid-operation: return to IDLE on the next edge. dmem_req drops and no done is issued. Byte beats already written stay written.
- Accept: lsu_valid && lsu_ready in IDLE latches wr_en, size, unsigned, addr and wr_data. lsu_valid is ignored outside IDLE.
- Byte count n: BYTE = 1, HALF_WORD = 2, WORD = 4.
- Misaligned: HALF_WORD with addr[0] = 1, or WORD with addr[1:0] != 0.
- Range check: compute end = addr + n - 1 in 33 bits, so 32-bit wrap counts as out of range. The access is out of range if end[32:DMEM_ADDR_WIDTH] != 0.
- Illegal size (any other encoding): treated as an error.
- States:
  - IDLE: on accept, go to ACCESS if aligned and legal; to SPLIT if misaligned, legal, and the feature is on; otherwise to RESP with an error.
  - ACCESS (1 cycle): dmem_req = 1 and the dmem_* outputs come from the latched request; dmem_zero_extend = unsigned. For loads, capture dmem_rd_data at the clock edge. Go to RESP.
  - SPLIT (n cycles): beat k = 0..n-1 drives dmem_addr = addr + k, size BYTE, zero_extend = 1, and dmem_wr_data = {24'b0, wr_data byte k}. For loads, capture dmem_rd_data[7:0] into assembly byte k. After beat n-1, extend the assembly (sign from bit 8n-1 unless unsigned) and go to RESP.
  - RESP (1 cycle): lsu_done = 1, lsu_err as determined; go to IDLE.
- Outside ACCESS/SPLIT, all dmem_* outputs are 0.
- lsu_rd_data is updated only on load completion and holds until the next load completes. It is 0 for errored loads. Stores leave it unchanged.
- Latency (accept at cycle 0):
  - Aligned: dmem_req in cycle 1, done in cycle 2.
  - Split: beats in cycles 1..n, done in cycle n+1.
  - Error: no dmem_req, done in cycle 1.
- Throughput: the next accept happens no earlier than the cycle after RESP.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: legal misaligned accesses are split into byte beats as above, with no error.
- Undefined: misaligned accesses complete with lsu_err = 1, no memory request, lsu_rd_data = 0, and the SPLIT state and beat counter are removed.

Decomposition:
- risc_pkg: reuse mem_size_t. Add the lsu_state_t enum (IDLE, ACCESS, SPLIT, RESP) and the size-to-byte-count function.
- One natural sub-module, lsu_load_extend: a combinational 32-bit assembly-to-result sign/zero extender per size and unsigned. It is used for split results; aligned results rely on dmem_zero_extend.

Test Plan:
- Aligned store/load: SW 0x100 = 0xDEADBEEF, then LW 0x100 → one dmem_req cycle each (WORD, addr 0x100); done 2 cycles after accept; rd_data = 0xDEADBEEF, err = 0.
- Sub-word loads on that data: LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE; LH 0x102 → 0xFFFFDEAD; LHU 0x100 → 0x0000BEEF.
- Misaligned LW 0x101 with the feature on → 4 BYTE beats at 0x101..0x104 with zero_extend = 1; done in cycle 5; rd_data equals the little-endian assembly. With the feature off → no dmem_req, done + err in cycle 1, rd_data = 0.
- Range with DMEM_ADDR_WIDTH = 16: LW 0xFFFC succeeds; LW 0xFFFE → err; LB 0x10000 → err; LW 0xFFFFFFFF → err (wrap). No dmem_req on any errored access.
- Reset mid-split: rst during beat 2 of SW 0x201 → next cycle dmem_req = 0, ready = 1, no done pulse; bytes at 0x201 and 0x202 already written.
- Back-to-back: lsu_valid held high with 3 aligned LWs → accepts in cycles 0, 3, 6; lsu_ready low in between; exactly 3 done pulses.
